// File: rtl/regfile_wb_scoreboard.sv
// Architectural register file written from WB, with two combinational ID read
// ports (write-through from WB) and a per-register pending-write scoreboard
// that ID uses to stall on a register that still has a write in flight.
module regfile_wb_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_waddr_i,
  input  logic        retire_i,
  input  logic [4:0]  retire_addr_i,
  input  logic        flush_i,
  output logic        busy1_o,
  output logic        busy2_o,
  output logic        sb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Flattened views of every entry so the read ports can mux over them.
  logic [NUM_REGS-1:0][31:0]      reg_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0]            err_hit;
  logic                           sb_err_reg;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Per-register storage and pending-write counter
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        // Register 0 is hardwired zero and never scoreboarded.
        assign reg_q[gi]   = '0;
        assign cnt_q[gi]   = '0;
        assign err_hit[gi] = 1'b0;
      end else begin : g_live
        logic [31:0]      data_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             inc;
        logic             dec;
        logic             err_next;

        assign inc = issue_we_i && (issue_waddr_i == 5'(gi));
        assign dec = retire_i && (retire_addr_i == 5'(gi));

        // Counter update: flush wins, otherwise saturate at both ends and flag.
        always_comb begin
          cnt_next = cnt_reg;
          err_next = 1'b0;
          if (flush_i) begin
            cnt_next = CNT_ZERO;
          end else if (inc && !dec) begin
            if (cnt_reg == CNT_MAX) begin
              err_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end else if (dec && !inc) begin
            if (cnt_reg == CNT_ZERO) begin
              err_next = 1'b1;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
        end

        // Register contents: captured from WB on a write to this entry.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            data_reg <= '0;
          end else if (wb_we_i && (wb_waddr_i == 5'(gi))) begin
            data_reg <= wb_wdata_i;
          end
        end

        // Pending-write counter state.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        assign reg_q[gi]   = data_reg;
        assign cnt_q[gi]   = cnt_reg;
        assign err_hit[gi] = err_next;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky scoreboard error
  // ---------------------------------------------------------------------------
  // Any overflow or underflow on any entry latches the error until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb_err_reg <= 1'b0;
    end else if (|err_hit) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err_o = sb_err_reg;

  // ---------------------------------------------------------------------------
  // Read ports: identical logic instantiated once per port
  // ---------------------------------------------------------------------------
  logic [1:0][4:0]  raddr_v;
  logic [1:0][31:0] rdata_v;
  logic [1:0]       busy_v;

  assign raddr_v[0] = raddr1_i;
  assign raddr_v[1] = raddr2_i;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0]      sel_data;
      logic [CNT_W-1:0] sel_cnt;
      logic             addr_nz;
      logic             fwd_hit;
      logic             last_retire;

      // Select the stored value and pending count for this port's address.
      always_comb begin
        sel_data = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (raddr_v[gi] == 5'(i)) begin
            sel_data = reg_q[i];
            sel_cnt  = cnt_q[i];
          end
        end
      end

      assign addr_nz = (raddr_v[gi] != 5'd0);
      assign fwd_hit = wb_we_i && (wb_waddr_i == raddr_v[gi]);
      // The final outstanding write retiring this cycle is already visible via
      // write-through, so ID need not stall on it.
      assign last_retire = retire_i && (retire_addr_i == raddr_v[gi]) &&
                           (sel_cnt == CNT_ONE);

      assign rdata_v[gi] = !addr_nz ? 32'd0 :
                           fwd_hit  ? wb_wdata_i : sel_data;
      assign busy_v[gi]  = addr_nz && (sel_cnt != CNT_ZERO) && !last_retire;
    end
  endgenerate

  assign rdata1_o = rdata_v[0];
  assign rdata2_o = rdata_v[1];
  assign busy1_o  = busy_v[0];
  assign busy2_o  = busy_v[1];

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed plus short random bench for regfile_wb_scoreboard. A behavioural
// model predicts outputs when stimulus is applied; predictions are queued and
// popped for comparison against the DUT's combinational outputs mid-cycle.
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic        retire;
  logic [4:0]  retire_addr;
  logic        flush;
  logic        busy1;
  logic        busy2;
  logic        sb_err;

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .wb_we_i      (wb_we),
    .wb_waddr_i   (wb_waddr),
    .wb_wdata_i   (wb_wdata),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .rdata1_o     (rdata1),
    .rdata2_o     (rdata2),
    .issue_we_i   (issue_we),
    .issue_waddr_i(issue_waddr),
    .retire_i     (retire),
    .retire_addr_i(retire_addr),
    .flush_i      (flush),
    .busy1_o      (busy1),
    .busy2_o      (busy2),
    .sb_err_o     (sb_err)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_cnt[a] == 0) return 1'b0;
    if (retire && retire_addr == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Apply one rising edge of the current inputs to the model.
  task automatic model_edge();
    bit inc;
    bit dec;
    if (wb_we && wb_waddr != 5'd0) m_regs[wb_waddr] = wb_wdata;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc = issue_we && (int'(issue_waddr) == r);
        dec = retire && (int'(retire_addr) == r);
        if (inc && !dec) begin
          if (m_cnt[r] == 3) m_err = 1'b1;
          else m_cnt[r] = m_cnt[r] + 1;
        end else if (dec && !inc) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r] = m_cnt[r] - 1;
        end
      end
    end
  endtask

  task automatic expect_now();
    exp_t e;
    e.r1  = m_read(raddr1);
    e.r2  = m_read(raddr2);
    e.b1  = m_busy(raddr1);
    e.b2  = m_busy(raddr2);
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: no expectation queued", tag);
    end else begin
      e = exp_q.pop_front();
      $display("step %s: rdata1=%h rdata2=%h busy1=%b busy2=%b sb_err=%b",
               tag, rdata1, rdata2, busy1, busy2, sb_err);
      checks++;
      assert (rdata1 === e.r1) else begin
        errors++;
        $error("FAIL %s rdata1: observed %h expected %h", tag, rdata1, e.r1);
      end
      checks++;
      assert (rdata2 === e.r2) else begin
        errors++;
        $error("FAIL %s rdata2: observed %h expected %h", tag, rdata2, e.r2);
      end
      checks++;
      assert (busy1 === e.b1) else begin
        errors++;
        $error("FAIL %s busy1: observed %b expected %b", tag, busy1, e.b1);
      end
      checks++;
      assert (busy2 === e.b2) else begin
        errors++;
        $error("FAIL %s busy2: observed %b expected %b", tag, busy2, e.b2);
      end
      checks++;
      assert (sb_err === e.err) else begin
        errors++;
        $error("FAIL %s sb_err: observed %b expected %b", tag, sb_err, e.err);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iw, input logic [4:0] ia,
                       input logic rt, input logic [4:0] ra, input logic fl);
    wb_we       = we;
    wb_waddr    = wa;
    wb_wdata    = wd;
    raddr1      = r1;
    raddr2      = r2;
    issue_we    = iw;
    issue_waddr = ia;
    retire      = rt;
    retire_addr = ra;
    flush       = fl;
  endtask

  // Predict and check mid-cycle, then advance one edge in DUT and model.
  task automatic step(input string tag);
    #1;
    expect_now();
    check(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 0);                     step("reset_read");

    // Write r7, then attempt r0
    drive(1, 7, 32'hDEADBEEF, 7, 0, 0, 0, 0, 0, 0);          step("wr_r7_through");
    drive(1, 0, 32'h12345678, 7, 0, 0, 0, 0, 0, 0);          step("wr_r0");
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);                     step("rd_r7_r0");

    // Write-through of a fresh register
    drive(1, 9, 32'hA5A5A5A5, 9, 7, 0, 0, 0, 0, 0);          step("wt_r9");
    drive(0, 0, 0, 9, 9, 0, 0, 0, 0, 0);                     step("rd_r9");

    // Scoreboard lifetime on r3
    drive(0, 0, 0, 3, 0, 1, 3, 0, 0, 0);                     step("issue_r3_a");
    drive(0, 0, 0, 3, 0, 1, 3, 0, 0, 0);                     step("issue_r3_b");
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);                     step("r3_cnt2");
    drive(1, 3, 32'h11111111, 3, 0, 0, 0, 1, 3, 0);          step("retire_r3_a");
    drive(1, 3, 32'h33333333, 3, 0, 0, 0, 1, 3, 0);          step("retire_r3_last");
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);                     step("r3_idle");

    // Simultaneous issue/retire and flush
    drive(0, 0, 0, 4, 0, 1, 4, 0, 0, 0);                     step("issue_r4");
    drive(0, 0, 0, 4, 0, 1, 4, 1, 4, 0);                     step("inc_dec_r4");
    drive(0, 0, 0, 4, 10, 1, 10, 1, 4, 0);                   step("issue10_ret4");
    drive(0, 0, 0, 4, 10, 0, 0, 0, 0, 0);                    step("r4_r10_idle");
    drive(0, 0, 0, 4, 10, 1, 4, 0, 0, 0);                    step("reissue_r4");
    drive(1, 5, 32'h55AA55AA, 4, 10, 1, 4, 0, 0, 1);         step("flush_issue");
    drive(0, 0, 0, 4, 5, 0, 0, 0, 0, 0);                     step("post_flush");
    drive(0, 0, 0, 10, 5, 0, 0, 0, 0, 0);                    step("post_flush_r10");

    // Underflow and overflow
    drive(0, 0, 0, 6, 0, 0, 0, 1, 6, 0);                     step("underflow_r6");
    drive(0, 0, 0, 6, 0, 0, 0, 0, 0, 0);                     step("err_set");
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 8, 6, 1, 8, 0, 0, 0);                   step($sformatf("issue_r8_%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 8, 0, 0, 0, 1, 8, 0);                   step($sformatf("retire_r8_%0d", k));
    end
    drive(0, 0, 0, 8, 0, 0, 0, 0, 0, 0);                     step("r8_drained");

    // Short random phase on a few low registers
    for (int k = 0; k < 24; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0));
      step($sformatf("rand_%0d", k));
    end

    // Asynchronous reset mid-cycle, and no write while held in reset
    drive(0, 0, 0, 7, 9, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_now();
    check("async_reset");
    drive(1, 7, 32'hCAFEF00D, 0, 0, 1, 7, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 7, 9, 0, 0, 0, 0, 0);                     step("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Write-side counterpart to the ID-stage operand read/bypass logic.
- Holds the 32x32 architectural register file, written from WB.
- Serves two combinational ID read ports with write-through, so a same-cycle WB write is visible to ID.
- Keeps a per-register pending-write scoreboard: ID issue of a writing instruction sets it, WB retire clears it, a pipeline flush discards it. ID uses the busy flags to stall instead of forwarding from EX.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- wb_we_i  input  1  WB-stage write enable.
- wb_waddr_i  input  5  WB destination register.
- wb_wdata_i  input  32  WB write data.
- raddr1_i  input  5  ID read address, port 1.
- raddr2_i  input  5  ID read address, port 2.
- rdata1_o  output  32  read data, port 1 (combinational).
- rdata2_o  output  32  read data, port 2 (combinational).
- issue_we_i  input  1  ID issues an instruction that will write a register (qualified by no stall).
- issue_waddr_i  input  5  destination of the issued instruction.
- retire_i  input  1  a scoreboarded write leaves WB this cycle (normally tied to wb_we_i).
- retire_addr_i  input  5  register being retired.
- flush_i  input  1  pipeline flush; discards all in-flight writes.
- busy1_o  output  1  raddr1_i has a pending write not yet retired.
- busy2_o  output  1  raddr2_i has a pending write not yet retired.
- sb_err_o  output  1  sticky scoreboard error (overflow or underflow).

Behaviour:
- Reset (rst_n_i=0, asynchronous): all registers clear to 0x00000000; all counters clear to 0; sb_err_o=0. Outputs are then: rdata*=0, busy*=0.
- Write:
  - At the rising edge with wb_we_i=1 and wb_waddr_i!=0, regs[wb_waddr_i] <= wb_wdata_i.
  - A write to register 0 is ignored.
- Read (0-cycle latency):
  - rdataN_o = 0 if raddrN_i==0.
  - Otherwise rdataN_o = wb_wdata_i if wb_we_i and wb_waddr_i==raddrN_i.
  - Otherwise rdataN_o = regs[raddrN_i].
- Scoreboard: cnt[r] is CNT_W bits; cnt[0] is always 0, and issue/retire to register 0 are ignored. Per edge, for each register r:
  - inc = issue_we_i && issue_waddr_i==r.
  - dec = retire_i && retire_addr_i==r.
  - Only inc: cnt+1.
  - Only dec: cnt-1.
  - inc and dec together: cnt unchanged.
- Flush:
  - flush_i=1 sets every counter to 0 at the edge. It overrides issue and retire in the same cycle.
  - Register writes in that cycle still occur.
- Overflow: inc with cnt at max saturates (no wrap) and sets sb_err_o.
- Underflow: dec with cnt=0 holds 0 and sets sb_err_o.
- sb_err_o stays set until reset.
- Busy outputs:
  - busyN_o = (cnt[raddrN_i]!=0) && raddrN_i!=0.
  - If dec targets raddrN_i this cycle and cnt==1, busyN_o=0 in the same cycle. This lets ID proceed using the write-through data.
- Simultaneous events:
  - Issue and retire to different registers both take effect.
  - Issue to the register being read does not affect busy in the same cycle; it takes effect next cycle.
- Reset mid-operation: pending counts and register contents are lost. No write occurs while rst_n_i=0.

Test Plan:
- Reset then read: rst_n_i=0 then 1; raddr1=5, raddr2=0 -> rdata1=0, rdata2=0, busy1=busy2=0, sb_err=0.
- Write/read-back and r0: write 0xDEADBEEF to r7 and then 0x12345678 to r0 -> raddr1=7 gives 0xDEADBEEF; raddr2=0 gives 0.
- Write-through: wb_we=1, waddr=9, wdata=0xA5A5A5A5, raddr1=9 in the same cycle -> rdata1=0xA5A5A5A5 that cycle.
- Scoreboard lifetime:
  - Issue r3 twice on consecutive cycles -> busy1 (raddr1=3) is 1 from the next cycle.
  - First retire of r3 -> still busy.
  - Second retire with cnt=1 -> busy1=0 in that same cycle; cnt=0 afterwards.
- Simultaneous and flush:
  - Issue and retire r4 in the same cycle with cnt=1 -> cnt stays 1.
  - Then flush_i=1 together with issue r4 -> all counters 0, busy=0 next cycle.
- Errors:
  - Retire r6 with cnt=0 -> sb_err=1, cnt stays 0.
  - Four issues to r8 -> cnt saturates at 3 and sb_err stays 1.
  - Assert async reset mid-cycle -> sb_err=0 immediately.
